// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered, handshaked MIPS decode stage with load-use and mulu interlocks
module decode_stage #(
   parameter int MUL_LATENCY  = 4,
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        memtoreg,
   output logic        memwrite,
   output logic        alusrcbimm,
   output logic        shift16left,
   output logic        regwrite,
   output logic        dojal,
   output logic        dojr,
   output logic        dojump,
   output logic [1:0]  brtype,
   output logic [4:0]  destreg,
   output logic [2:0]  alucontrol,
   output logic        illegal
);
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MULU = 6'h19;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   logic [5:0] op, fn;
   logic [4:0] rs, rt, rd;
   assign op = instr[31:26];
   assign rs = instr[25:21];
   assign rt = instr[20:16];
   assign rd = instr[15:11];
   assign fn = instr[5:0];

   logic       d_memtoreg, d_memwrite, d_alusrcbimm, d_shift16left;
   logic       d_regwrite, d_dojal, d_dojr, d_dojump, d_illegal;
   logic [1:0] d_brtype;
   logic [4:0] d_destreg;
   logic [2:0] d_alu;
   logic       rs_used, rt_used, d_mul_class, d_mulu;
   logic       r_write;
   logic [2:0] r_alu;

   always_comb begin
      d_memtoreg    = 1'b0;
      d_memwrite    = 1'b0;
      d_alusrcbimm  = 1'b0;
      d_shift16left = 1'b0;
      d_regwrite    = 1'b0;
      d_dojal       = 1'b0;
      d_dojr        = 1'b0;
      d_dojump      = 1'b0;
      d_illegal     = 1'b0;
      d_brtype      = 2'b00;
      d_destreg     = 5'd0;
      d_alu         = 3'b000;
      rs_used       = 1'b1;
      rt_used       = 1'b0;
      d_mul_class   = 1'b0;
      d_mulu        = 1'b0;
      r_write       = 1'b0;
      r_alu         = 3'b000;
      case (op)
         OP_RTYPE: begin
            rt_used = 1'b1;
            case (fn)
               FN_ADDU: begin r_write = 1'b1; r_alu = 3'b010; end
               FN_SUBU: begin r_write = 1'b1; r_alu = 3'b110; end
               FN_AND:  begin r_write = 1'b1; r_alu = 3'b000; end
               FN_OR:   begin r_write = 1'b1; r_alu = 3'b001; end
               FN_SLTU: begin r_write = 1'b1; r_alu = 3'b111; end
               FN_MFHI: begin r_write = 1'b1; r_alu = 3'b100; d_mul_class = 1'b1; end
               FN_MFLO: begin r_write = 1'b1; r_alu = 3'b101; d_mul_class = 1'b1; end
               FN_MULU: begin r_write = 1'b1; r_alu = 3'b011; d_mul_class = 1'b1; d_mulu = 1'b1; end
               FN_JR:   d_dojr = 1'b1;
               default: d_illegal = ILLEGAL_TRAP;
            endcase
            if (r_write) begin
               d_regwrite = 1'b1;
               d_destreg  = rd;
               d_alu      = r_alu;
            end
         end
         // Only rt == 0 (bltz) is implemented in the REGIMM group.
         OP_REGIMM: begin
            if (rt == 5'd0) begin
               d_alu    = 3'b111;
               d_brtype = 2'b10;
            end else begin
               d_illegal = ILLEGAL_TRAP;
            end
         end
         OP_J: begin
            d_dojump = 1'b1;
            rs_used  = 1'b0;
         end
         OP_JAL: begin
            d_dojump   = 1'b1;
            d_dojal    = 1'b1;
            d_regwrite = 1'b1;
            d_destreg  = 5'd31;
            rs_used    = 1'b0;
         end
         OP_BEQ: begin
            d_alu    = 3'b110;
            d_brtype = 2'b01;
            rt_used  = 1'b1;
         end
         OP_ADDIU, OP_ORI: begin
            d_alu        = (op == OP_ORI) ? 3'b001 : 3'b010;
            d_alusrcbimm = 1'b1;
            d_regwrite   = 1'b1;
            d_destreg    = rt;
         end
         OP_LUI: begin
            d_shift16left = 1'b1;
            d_alu         = 3'b010;
            d_alusrcbimm  = 1'b1;
            d_regwrite    = 1'b1;
            d_destreg     = rt;
            rs_used       = 1'b0;
         end
         OP_LW: begin
            d_alu        = 3'b010;
            d_alusrcbimm = 1'b1;
            d_regwrite   = 1'b1;
            d_memtoreg   = 1'b1;
            d_destreg    = rt;
         end
         OP_SW: begin
            d_alu        = 3'b010;
            d_alusrcbimm = 1'b1;
            d_memwrite   = 1'b1;
            rt_used      = 1'b1;
         end
         default: d_illegal = ILLEGAL_TRAP;
      endcase
   end

   logic [3:0] mul_cnt;
   logic       lu_haz, mul_haz, xfer;

   // memtoreg is only ever set by lw, so it marks a load in the output register.
   assign lu_haz  = out_valid && memtoreg && (destreg != 5'd0) &&
                    ((rs_used && (rs == destreg)) || (rt_used && (rt == destreg)));
   assign mul_haz = (mul_cnt != 4'd0) && d_mul_class;
   assign in_ready = !reset && (!out_valid || out_ready) && !lu_haz && !mul_haz && !flush;
   assign xfer     = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_pc      <= 32'd0;
         out_instr   <= 32'd0;
         memtoreg    <= 1'b0;
         memwrite    <= 1'b0;
         alusrcbimm  <= 1'b0;
         shift16left <= 1'b0;
         regwrite    <= 1'b0;
         dojal       <= 1'b0;
         dojr        <= 1'b0;
         dojump      <= 1'b0;
         brtype      <= 2'b00;
         destreg     <= 5'd0;
         alucontrol  <= 3'b000;
         illegal     <= 1'b0;
         mul_cnt     <= 4'd0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (xfer) begin
            out_valid   <= 1'b1;
            out_pc      <= pc;
            out_instr   <= instr;
            memtoreg    <= d_memtoreg;
            memwrite    <= d_memwrite;
            alusrcbimm  <= d_alusrcbimm;
            shift16left <= d_shift16left;
            regwrite    <= d_regwrite;
            dojal       <= d_dojal;
            dojr        <= d_dojr;
            dojump      <= d_dojump;
            brtype      <= d_brtype;
            destreg     <= d_destreg;
            alucontrol  <= d_alu;
            illegal     <= d_illegal;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (xfer && d_mulu) begin
            mul_cnt <= 4'(MUL_LATENCY);
         end else if (mul_cnt != 4'd0) begin
            mul_cnt <= mul_cnt - 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed bench for decode_stage with a mnemonic-level reference model
module tb_decode_stage;
   localparam int MUL_LAT = 4;

   typedef struct packed {
      logic       memtoreg, memwrite, alusrcbimm, shift16left, regwrite, dojal, dojr, dojump;
      logic [1:0] brtype;
      logic [4:0] destreg;
      logic [2:0] alucontrol;
      logic       illegal;
   } bundle_t;

   typedef enum {M_ADDU, M_SUBU, M_AND, M_OR, M_SLTU, M_MFHI, M_MFLO, M_MULU, M_JR,
                 M_LW, M_SW, M_BEQ, M_BLTZ, M_ADDIU, M_ORI, M_LUI, M_J, M_JAL, M_BAD} mn_t;

   logic clk, reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] instr, pc, out_pc, out_instr;
   logic memtoreg, memwrite, alusrcbimm, shift16left, regwrite, dojal, dojr, dojump, illegal;
   logic [1:0] brtype;
   logic [4:0] destreg;
   logic [2:0] alucontrol;
   logic u2_in_ready, u2_out_valid;
   logic [31:0] u2_out_pc, u2_out_instr;
   logic u2_memtoreg, u2_memwrite, u2_alusrcbimm, u2_shift16left, u2_regwrite;
   logic u2_dojal, u2_dojr, u2_dojump, u2_illegal;
   logic [1:0] u2_brtype;
   logic [4:0] u2_destreg;
   logic [2:0] u2_alucontrol;

   decode_stage #(.MUL_LATENCY(MUL_LAT), .ILLEGAL_TRAP(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .memtoreg(memtoreg), .memwrite(memwrite), .alusrcbimm(alusrcbimm),
      .shift16left(shift16left), .regwrite(regwrite), .dojal(dojal), .dojr(dojr), .dojump(dojump),
      .brtype(brtype), .destreg(destreg), .alucontrol(alucontrol), .illegal(illegal));

   decode_stage #(.MUL_LATENCY(MUL_LAT), .ILLEGAL_TRAP(1'b0)) dut_notrap (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u2_in_ready), .instr(instr), .pc(pc),
      .flush(flush), .out_valid(u2_out_valid), .out_ready(out_ready), .out_pc(u2_out_pc),
      .out_instr(u2_out_instr), .memtoreg(u2_memtoreg), .memwrite(u2_memwrite),
      .alusrcbimm(u2_alusrcbimm), .shift16left(u2_shift16left), .regwrite(u2_regwrite),
      .dojal(u2_dojal), .dojr(u2_dojr), .dojump(u2_dojump), .brtype(u2_brtype),
      .destreg(u2_destreg), .alucontrol(u2_alucontrol), .illegal(u2_illegal));

   bundle_t dut_b, dut2_b;
   assign dut_b  = {memtoreg, memwrite, alusrcbimm, shift16left, regwrite, dojal, dojr, dojump,
                    brtype, destreg, alucontrol, illegal};
   assign dut2_b = {u2_memtoreg, u2_memwrite, u2_alusrcbimm, u2_shift16left, u2_regwrite, u2_dojal,
                    u2_dojr, u2_dojump, u2_brtype, u2_destreg, u2_alucontrol, u2_illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic mn_t classify(input logic [31:0] w);
      mn_t m;
      m = M_BAD;
      if (w[31:26] == 6'd0) begin
         case (w[5:0])
            6'h21: m = M_ADDU;  6'h23: m = M_SUBU;  6'h24: m = M_AND;
            6'h25: m = M_OR;    6'h2B: m = M_SLTU;  6'h10: m = M_MFHI;
            6'h12: m = M_MFLO;  6'h19: m = M_MULU;  6'h08: m = M_JR;
            default: m = M_BAD;
         endcase
      end else begin
         case (w[31:26])
            6'h23: m = M_LW;    6'h2B: m = M_SW;    6'h04: m = M_BEQ;
            6'h09: m = M_ADDIU; 6'h0D: m = M_ORI;   6'h0F: m = M_LUI;
            6'h02: m = M_J;     6'h03: m = M_JAL;
            6'h01: m = (w[20:16] == 5'd0) ? M_BLTZ : M_BAD;
            default: m = M_BAD;
         endcase
      end
      return m;
   endfunction

   function automatic bundle_t ref_decode(input logic [31:0] w, input bit trap);
      bundle_t b;
      mn_t m;
      b = '0;
      m = classify(w);
      case (m)
         M_ADDU: begin b.regwrite = 1; b.destreg = w[15:11]; b.alucontrol = 3'b010; end
         M_SUBU: begin b.regwrite = 1; b.destreg = w[15:11]; b.alucontrol = 3'b110; end
         M_AND:  begin b.regwrite = 1; b.destreg = w[15:11]; b.alucontrol = 3'b000; end
         M_OR:   begin b.regwrite = 1; b.destreg = w[15:11]; b.alucontrol = 3'b001; end
         M_SLTU: begin b.regwrite = 1; b.destreg = w[15:11]; b.alucontrol = 3'b111; end
         M_MFHI: begin b.regwrite = 1; b.destreg = w[15:11]; b.alucontrol = 3'b100; end
         M_MFLO: begin b.regwrite = 1; b.destreg = w[15:11]; b.alucontrol = 3'b101; end
         M_MULU: begin b.regwrite = 1; b.destreg = w[15:11]; b.alucontrol = 3'b011; end
         M_JR:   b.dojr = 1;
         M_LW:   begin b.alucontrol = 3'b010; b.alusrcbimm = 1; b.regwrite = 1; b.memtoreg = 1; b.destreg = w[20:16]; end
         M_SW:   begin b.alucontrol = 3'b010; b.alusrcbimm = 1; b.memwrite = 1; end
         M_BEQ:  begin b.alucontrol = 3'b110; b.brtype = 2'b01; end
         M_BLTZ: begin b.alucontrol = 3'b111; b.brtype = 2'b10; end
         M_ADDIU: begin b.alucontrol = 3'b010; b.alusrcbimm = 1; b.regwrite = 1; b.destreg = w[20:16]; end
         M_ORI:  begin b.alucontrol = 3'b001; b.alusrcbimm = 1; b.regwrite = 1; b.destreg = w[20:16]; end
         M_LUI:  begin b.shift16left = 1; b.alucontrol = 3'b010; b.alusrcbimm = 1; b.regwrite = 1; b.destreg = w[20:16]; end
         M_J:    b.dojump = 1;
         M_JAL:  begin b.dojump = 1; b.dojal = 1; b.regwrite = 1; b.destreg = 5'd31; end
         default: b.illegal = trap;
      endcase
      return b;
   endfunction

   function automatic bit reads_rs(input logic [31:0] w);
      mn_t m;
      m = classify(w);
      return !(m == M_J || m == M_JAL || m == M_LUI);
   endfunction

   function automatic bit reads_rt(input logic [31:0] w);
      mn_t m;
      m = classify(w);
      return (w[31:26] == 6'd0) || m == M_BEQ || m == M_SW;
   endfunction

   // Reference state: what the output register holds, plus when the last mulu entered.
   bit      m_valid = 0, m_zero = 0, started = 0;
   bundle_t m_b = '0, m_b2 = '0;
   mn_t     m_mn = M_BAD;
   logic [31:0] m_pc = 0, m_instr = 0;
   int      cyc = 0, last_mul = -1000;

   function automatic bit exp_ready();
      bit lu, mh;
      mn_t m;
      m  = classify(instr);
      lu = m_valid && (m_mn == M_LW) && (m_b.destreg != 5'd0) &&
           ((reads_rs(instr) && instr[25:21] == m_b.destreg) ||
            (reads_rt(instr) && instr[20:16] == m_b.destreg));
      mh = ((cyc - last_mul) <= MUL_LAT) && (m == M_MFHI || m == M_MFLO || m == M_MULU);
      return !reset && (!m_valid || out_ready) && !lu && !mh && !flush;
   endfunction

   always @(posedge clk) begin
      bit t;
      t = in_valid && exp_ready();
      if (reset) begin
         m_valid = 0; m_zero = 1; started = 1;
         m_b = '0; m_b2 = '0; m_mn = M_BAD; m_pc = 0; m_instr = 0; last_mul = -1000;
      end else if (flush) begin
         m_valid = 0;
      end else if (t) begin
         m_valid = 1; m_zero = 0;
         m_b = ref_decode(instr, 1'b1); m_b2 = ref_decode(instr, 1'b0);
         m_mn = classify(instr); m_pc = pc; m_instr = instr;
         if (m_mn == M_MULU) last_mul = cyc;
      end else if (out_ready) begin
         m_valid = 0;
      end
      cyc++;
   end

   int      acc_cyc[$];
   int      cons_cyc[$];
   bundle_t cons_b[$];

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", in_ready, exp_ready());
         chk("out_valid", out_valid, m_valid);
         chk("notrap_out_valid", u2_out_valid, m_valid);
         if (m_valid || m_zero) begin
            chk("bundle", dut_b, m_b);
            chk("out_pc", out_pc, m_pc);
            chk("out_instr", out_instr, m_instr);
            chk("notrap_bundle", dut2_b, m_b2);
         end
         if (in_valid && in_ready) acc_cyc.push_back(cyc);
         if (out_valid && out_ready) begin
            cons_cyc.push_back(cyc);
            cons_b.push_back(dut_b);
         end
      end
   end

   task automatic send(input logic [31:0] w, input logic [31:0] p);
      bit done;
      done = 0;
      in_valid = 1; instr = w; pc = p;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      in_valid = 0; instr = 0;
      if (!done) begin
         checks++; failures++;
         $display("FAIL send_timeout got=no_accept expected=accept instr=%h", w);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      acc_cyc.delete(); cons_cyc.delete(); cons_b.delete();
   endtask

   localparam logic [31:0] I_ADDU  = 32'h00221821;   // addu $3,$1,$2
   localparam logic [31:0] I_ORI   = 32'h34040005;   // ori $4,$0,5
   localparam logic [31:0] I_J     = 32'h08000010;
   localparam logic [31:0] I_BEQ   = 32'h10220003;   // beq $1,$2,3
   localparam logic [31:0] I_BAD   = 32'hFC000000;

   initial begin
      bundle_t b;
      int rc;
      in_valid = 0; instr = 0; pc = 0; flush = 0; out_ready = 1; reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_regwrite", regwrite, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // back-to-back stream
      clear_logs();
      chk("enc_addu", rtype(1, 2, 3, 'h21), I_ADDU);
      chk("enc_ori", itype('h0D, 0, 4, 5), I_ORI);
      send(I_ADDU, 32'h100); send(I_ORI, 32'h104); send(I_J, 32'h108);
      idle(3);
      chk("s_acc_n", acc_cyc.size(), 3);
      chk("s_acc_gap01", acc_cyc[1] - acc_cyc[0], 1);
      chk("s_acc_gap12", acc_cyc[2] - acc_cyc[1], 1);
      chk("s_lat", cons_cyc[0] - acc_cyc[0], 1);
      b = cons_b[0];
      chk("s_addu_alu", b.alucontrol, 3'b010); chk("s_addu_dest", b.destreg, 3);
      b = cons_b[1];
      chk("s_ori_alu", b.alucontrol, 3'b001); chk("s_ori_dest", b.destreg, 4);
      chk("s_ori_imm", b.alusrcbimm, 1);
      b = cons_b[2];
      chk("s_j_jump", b.dojump, 1); chk("s_j_regwrite", b.regwrite, 0);

      // load-use: one bubble; loads to $0 never interlock
      clear_logs();
      send(itype('h23, 1, 5, 0), 32'h200); send(rtype(5, 2, 6, 'h21), 32'h204);
      idle(3);
      chk("lu_acc_gap", acc_cyc[1] - acc_cyc[0], 2);
      chk("lu_bubble", cons_cyc[1] - cons_cyc[0], 2);
      clear_logs();
      send(itype('h23, 1, 0, 0), 32'h210); send(rtype(0, 2, 6, 'h21), 32'h214);
      idle(3);
      chk("lu0_acc_gap", acc_cyc[1] - acc_cyc[0], 1);

      // mulu interlock: independent addu passes, mflo waits
      clear_logs();
      send(rtype(1, 2, 0, 'h19), 32'h300); send(I_ADDU, 32'h304); send(rtype(0, 0, 7, 'h12), 32'h308);
      idle(3);
      chk("mul_addu_gap", acc_cyc[1] - acc_cyc[0], 1);
      chk("mul_mflo_gap", acc_cyc[2] - acc_cyc[0], MUL_LAT + 1);

      // back-pressure on a held beq
      out_ready = 0;
      send(I_BEQ, 32'h400);
      in_valid = 1; instr = I_ADDU; pc = 32'h404;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_brtype", brtype, 2'b01);
         chk("bp_alu", alucontrol, 3'b110);
         chk("bp_instr", out_instr, I_BEQ);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1;
      @(negedge clk);
      chk("bp_release", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0; instr = 0;
      idle(2);

      // flush wins over a pending input
      clear_logs();
      send(I_ADDU, 32'h500);
      in_valid = 1; instr = I_ORI; pc = 32'h504; flush = 1;
      @(negedge clk);
      chk("fl_in_ready", in_ready, 0);
      @(posedge clk); #1;
      flush = 0; in_valid = 0; instr = 0;
      @(negedge clk);
      chk("fl_out_valid", out_valid, 0);
      chk("fl_no_capture", acc_cyc.size(), 1);
      @(posedge clk); #1;

      // undefined opcode
      send(I_BAD, 32'h600);
      @(negedge clk);
      chk("ill_flag", illegal, 1);
      chk("ill_enables", {memtoreg, memwrite, regwrite, dojal, dojr, dojump, brtype}, 0);
      chk("ill_notrap", u2_illegal, 0);
      @(posedge clk); #1;
      idle(2);

      // reset in the middle of a mul stall
      clear_logs();
      send(rtype(1, 2, 0, 'h19), 32'h700);
      in_valid = 1; instr = rtype(0, 0, 7, 'h12); pc = 32'h704;
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      rc = cyc;
      @(negedge clk);
      chk("mr_out_valid", out_valid, 0);
      chk("mr_out_pc", out_pc, 0);
      chk("mr_out_instr", out_instr, 0);
      chk("mr_alu", alucontrol, 0);
      chk("mr_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0; instr = 0;
      idle(2);
      chk("mr_acc_n", acc_cyc.size(), 2);
      chk("mr_mflo_cycle", acc_cyc[1], rc);

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
